// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// ALU control codes, FSM state encoding and iteration count.
package muldiv_pkg;

    localparam int unsigned ITERS = 32;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the core and the multiply/divide unit.
interface muldiv_sequencer_if;

    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, op, rs1, rs2,
        input  busy, done, result
    );

    modport slave (
        input  start, op, rs1, rs2,
        output busy, done, result
    );

endinterface

// File: rtl/muldiv_sequencer_alu.sv
// Core 32-bit adder/subtractor with carry and Z/N/V flags.
// For subtraction the carry is the no-borrow flag (C=1 when a >= b unsigned).
module alu
    import muldiv_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  ctrl,
    output logic [31:0] sum,
    output logic        c,
    output logic        z,
    output logic        n,
    output logic        v
);

    logic        sub;
    logic [31:0] b_eff;
    logic [32:0] wide;

    // Two's-complement add/sub with carry out and flags.
    always_comb begin
        sub   = (ctrl == ALU_SUB);
        b_eff = sub ? ~b : b;
        wide  = {1'b0, a} + {1'b0, b_eff} + {32'b0, sub};
        sum   = wide[31:0];
        c     = wide[32];
        z     = (wide[31:0] == '0);
        n     = wide[31];
        v     = (a[31] == b_eff[31]) && (wide[31] != a[31]);
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU: 32 shift-add or restoring-subtract
// iterations on a private ALU. hi/r, lo/q and m/d share working registers.
module muldiv_sequencer
    import muldiv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    muldiv_sequencer_if.slave    bus
);

    state_t      state;
    state_t      state_next;
    logic [4:0]  cnt;
    logic [1:0]  op_q;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] m;
    logic [31:0] result_q;
    logic [31:0] hi_next;
    logic [31:0] lo_next;
    logic [31:0] s;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_sum;
    logic        alu_c;
    logic        is_div;
    logic        sel_hi;
    logic        last;

    alu u_alu (
        .a    (alu_a),
        .b    (alu_b),
        .ctrl (alu_ctrl),
        .sum  (alu_sum),
        .c    (alu_c),
        .z    (),
        .n    (),
        .v    ()
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state: IDLE -> RUN on start, RUN -> DONE after iteration 31, DONE -> IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        bus.busy   = (state != IDLE);
        bus.done   = (state == DONE);
        bus.result = result_q;
    end

    // ALU operands: active only in RUN, otherwise parked at 0 + 0.
    always_comb begin
        is_div   = (op_q == OP_DIVU) || (op_q == OP_REMU);
        sel_hi   = (op_q == OP_MULHU) || (op_q == OP_REMU);
        last     = (cnt == 5'(ITERS - 1));
        s        = {hi[30:0], lo[31]};
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = ALU_ADD;
        if (state == RUN) begin
            alu_b = m;
            if (is_div) begin
                alu_a    = s;
                alu_ctrl = ALU_SUB;
            end else begin
                alu_a = hi;
            end
        end
    end

    // One iteration: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        hi_next = hi;
        lo_next = lo;
        if (is_div) begin
            if (hi[31] | alu_c) begin
                hi_next = alu_sum;
                lo_next = {lo[30:0], 1'b1};
            end else begin
                hi_next = s;
                lo_next = {lo[30:0], 1'b0};
            end
        end else if (lo[0]) begin
            hi_next = {alu_c, alu_sum[31:1]};
            lo_next = {alu_sum[0], lo[31:1]};
        end else begin
            hi_next = {1'b0, hi[31:1]};
            lo_next = {hi[0], lo[31:1]};
        end
    end

    // Working registers, counter and result.
    // The result is loaded on the final RUN edge so it is already valid in
    // the DONE cycle together with done, and then held through IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            op_q     <= '0;
            hi       <= '0;
            lo       <= '0;
            m        <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q <= bus.op;
                        hi   <= '0;
                        lo   <= bus.rs1;
                        m    <= bus.rs2;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    hi  <= hi_next;
                    lo  <= lo_next;
                    cnt <= cnt + 5'd1;
                    if (last) result_q <= sel_hi ? hi_next : lo_next;
                end
                default: ;
            endcase
        end
    end

endmodule
